ahb_lite_sram_slave: RTL

//  AHB-lite slave with an internal SRAM array, configurable wait states and ERROR response.
//  It is the design block driven by the bench's AHB interface (drv_cb outputs -> this block's inputs).
//  Its Hrdata/Hreadyout/Hresp feed the monitor and scoreboard.

---
 rtl/ahb_pkg.sv | 40 ++++
 rtl/ahb_sram_bank.sv | 25 ++
 rtl/ahb_lite_sram_slave.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite types, response codes and the byte-lane decode used by the SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ERR1 = 3'd2,
        ST_ERR2 = 3'd3,
        ST_DATA = 3'd4
    } slv_state_e;

    // Little-endian lane mask; an illegal size yields no lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            HSIZE_BYTE: be = 4'b0001 << addr;
            HSIZE_HALF: be = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// Word-organised SRAM with per-byte write enables and an asynchronous read port.
module ahb_sram_bank #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [3:0]       i_we,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite SRAM slave: address-phase decode, wait-state/error FSM and data-phase control.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  Hsel,
    input  logic                  Hready,
    input  logic                  Hwrite,
    input  logic [2:0]            Hsize,
    input  logic [2:0]            Hburst,
    input  logic [1:0]            Htrans,
    input  logic [ADDR_WIDTH-1:0] Haddr,
    input  logic [DATA_WIDTH-1:0] Hwdata,
    output logic [DATA_WIDTH-1:0] Hrdata,
    output logic                  Hreadyout,
    output logic                  Hresp
);

    localparam int         IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slv_state_e            r_state;
    slv_state_e            w_next;
    logic [3:0]            r_wait_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [1:0]            r_lane;
    logic [2:0]            r_size;
    logic                  r_write;

    logic                  w_readyout;
    logic                  w_active_trans;
    logic                  w_accept;
    logic                  w_range_err;
    logic                  w_size_err;
    logic                  w_addr_err;
    logic [3:0]            w_we;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_unused_burst;

    // Burst type is informational; each beat carries its own address.
    assign w_unused_burst = ^Hburst;

    // Address phase: only sampled while this slave is ready.
    assign w_readyout     = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign w_active_trans = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);
    assign w_accept       = Hsel && Hready && w_active_trans && w_readyout;

    assign w_range_err = ({2'b00, Haddr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH));
    assign w_size_err  = (Hsize > HSIZE_WORD)
                      || ((Hsize == HSIZE_HALF) && Haddr[0])
                      || ((Hsize == HSIZE_WORD) && (Haddr[1:0] != 2'b00));
    assign w_addr_err  = w_range_err || w_size_err;

    always_ff @(posedge Hclk) begin
        if (w_accept) begin
            r_idx   <= Haddr[IDX_W+1:2];
            r_lane  <= Haddr[1:0];
            r_size  <= Hsize;
            r_write <= Hwrite;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_addr_err && (WAIT_STATES > 0)) begin
                r_wait_cnt <= WS_INIT;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!w_accept) begin
                    w_next = ST_IDLE;
                end else if (w_addr_err) begin
                    w_next = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    w_next = ST_WAIT;
                end else begin
                    w_next = ST_DATA;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_next = ST_DATA;
                end
            end
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    // Data phase: a write lands at the edge closing DATA, so a following read sees it.
    assign w_we = ((r_state == ST_DATA) && r_write && !Hreset) ? byte_en(r_size, r_lane) : 4'b0000;

    ahb_sram_bank #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_bank (
        .clk     (Hclk),
        .i_idx   (r_idx),
        .i_we    (w_we),
        .i_wdata (Hwdata),
        .o_rdata (w_mem_rdata)
    );

    assign Hreadyout = w_readyout;
    assign Hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign Hrdata    = ((r_state == ST_DATA) && !r_write) ? w_mem_rdata : '0;

endmodule
